// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time and
// buffers the returned word for decode. Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] id_instr_nx, id_pc_nx;
  logic        squash, squash_nx;
  logic        fault, fault_nx;
  logic [31:0] tgt;
  logic        misalign;
  logic        req_hs;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  assign tgt      = br_target;
  assign misalign = br_taken && (br_target[1:0] != 2'b00);
`else
  assign tgt      = br_target & ~32'h3;
  assign misalign = 1'b0;
`endif

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign id_valid       = (state == HOLD);
  assign fetch_fault    = fault;
  assign req_hs         = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      squash   <= 1'b0;
      id_instr <= '0;
      id_pc    <= RESET_PC;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      squash   <= squash_nx;
      id_instr <= id_instr_nx;
      id_pc    <= id_pc_nx;
      fault    <= fault_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    squash_nx   = squash;
    id_instr_nx = id_instr;
    id_pc_nx    = id_pc;
    fault_nx    = fault;
    // A misaligned redirect parks the FSM until reset; in-flight data is never consumed.
    if (misalign && state != HALT) begin
      fault_nx = 1'b1;
      state_nx = HALT;
    end else begin
      unique case (state)
        BOOT: begin
          state_nx = REQ;
          if (br_taken) pc_nx = tgt;
        end
        REQ: begin
          if (req_hs) begin
            state_nx = WAIT;
            if (br_taken) begin
              pc_nx     = tgt;
              squash_nx = 1'b1;
            end else begin
              id_pc_nx = pc;
            end
          end else if (br_taken) begin
            pc_nx = tgt;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (squash || br_taken) begin
              squash_nx = 1'b0;
              state_nx  = REQ;
              if (br_taken) pc_nx = tgt;
            end else begin
              id_instr_nx = imem_rsp_data;
              state_nx    = HOLD;
            end
          end else if (br_taken) begin
            pc_nx     = tgt;
            squash_nx = 1'b1;
          end
        end
        HOLD: begin
          if (br_taken) begin
            pc_nx    = tgt;
            state_nx = REQ;
          end else if (id_ready) begin
            pc_nx    = pc + 32'(PC_STEP);
            state_nx = REQ;
          end
        end
        HALT: state_nx = HALT;
        default: state_nx = BOOT;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the single-issue core: owns the program counter, issues one request at a time to instruction memory over a valid/ready handshake, and buffers the returned word for decode.
- Handles branch/jump redirects from execute, including squashing an in-flight request.
- Sits between the PC datapath, the imem port and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
br_taken  input  1  redirect request from execute, single-cycle pulse
br_target  input  32  redirect address, valid when br_taken=1
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request when valid&&ready
imem_req_addr  output  32  fetch address
imem_rsp_valid  input  1  read data valid, single-cycle pulse
imem_rsp_data  input  32  instruction word
id_valid  output  1  buffered instruction available to decode
id_ready  input  1  decode accepts when id_valid&&id_ready
id_instr  output  32  buffered instruction
id_pc  output  32  address of id_instr
fetch_fault  output  1  misaligned redirect flag; MISALIGN_TRAP_EN only, tied 0 otherwise

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - Reset values: state=BOOT, pc=RESET_PC, squash=0, imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=RESET_PC, fetch_fault=0.
  - Reset mid-operation discards any outstanding request and any buffered word. A response arriving after reset is ignored unless the FSM is in WAIT.
- Outputs:
  - imem_req_valid = (state==REQ). imem_req_addr = pc.
  - id_valid = (state==HOLD). id_instr and id_pc are registers.
- FSM states: BOOT, REQ, WAIT, HOLD.
- BOOT: goes to REQ on the next cycle. A br_taken in BOOT loads pc.
- REQ:
  - br_taken && !(valid&&ready): pc<=br_target, stay in REQ. The address changes the next cycle; imem samples only on handshake.
  - Handshake && br_taken: pc<=br_target, squash<=1, go to WAIT.
  - Handshake only: id_pc<=pc, go to WAIT.
- WAIT:
  - rsp_valid && (squash || br_taken): drop the data, squash<=0, go to REQ. If br_taken, also pc<=br_target.
  - rsp_valid otherwise: id_instr<=imem_rsp_data, go to HOLD. id_valid rises the cycle after rsp_valid (1-cycle capture latency).
  - br_taken without rsp_valid: pc<=br_target, squash<=1, stay in WAIT.
- HOLD:
  - br_taken has priority over an accept in the same cycle. The buffered word is discarded (not delivered), pc<=br_target, go to REQ.
  - id_valid && id_ready: pc<=pc+PC_STEP, go to REQ.
  - Otherwise hold; id_instr and id_pc stay stable.
- Invariants:
  - At most one outstanding imem request.
  - imem_rsp_valid outside WAIT is ignored.
  - pc+PC_STEP wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
  - Sustained throughput: one instruction per 3 cycles with zero-wait imem and always-ready decode.

Optional Feature:
- Macro: FETCH_CTRL_MISALIGN_TRAP_EN.
- Defined: a br_taken with br_target[1:0]!=0 sets fetch_fault, which is sticky until reset. The FSM enters HOLD-free halt: imem_req_valid=0 and id_valid=0 until reset. Any in-flight response is ignored.
- Undefined: br_target[1:0] is forced to 2'b00 on load, and fetch_fault is tied to 0.

Test Plan:
1. Reset for 2 cycles, imem always ready with rsp 1 cycle after handshake, id_ready=1. Required: requests at 0x0, 0x4, 0x8; id_pc matches; first id_valid 3 cycles after BOOT exit.
2. Handshake at 0x8, then br_taken target 0x100 while in WAIT, then rsp 0xDEADBEEF. Required: word dropped, next request 0x100, id_valid never shows 0xDEADBEEF.
3. HOLD with id_ready=0 for 5 cycles, then br_taken and id_ready same cycle to 0x40. Required: id_instr/id_pc stable for 5 cycles, no accept counted, next request 0x40.
4. Start pc=32'hFFFF_FFFC, accept instruction. Required: next imem_req_addr = 0x0.
5. imem_req_ready=0 for 4 cycles, br_taken 0x80 in cycle 2. Required: addr changes to 0x80, valid held high, handshake at 0x80 only.
6. With FETCH_CTRL_MISALIGN_TRAP_EN, br_target 0x102. Required: fetch_fault=1 next cycle, no further requests until reset. Without the macro: request to 0x100.
